// File: rtl/layer_result_collector_if.sv
// Output stream of one MLP layer: neuron words with index and last marker
// over a valid/ready handshake towards the next layer.
interface layer_result_collector_if #(
    parameter int W  = 32,
    parameter int IW = 8
);
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/layer_result_collector.sv
// Collects one dot-product result per neuron (optional ReLU), then streams the
// buffered layer vector downstream. Outputs are all driven from registers.
module layer_result_collector #(
    parameter int NEURONS = 10,
    parameter int W       = 32,
    parameter int IW      = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic [W-1:0]              result,
    input  logic                      endf,
    output logic                      dp_restart,
    layer_result_collector_if.master  out,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_COLLECT = 2'd1;
    localparam logic [1:0]    S_DRAIN   = 2'd2;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NEURONS - 1);
    localparam logic [IW-1:0] ZERO_IDX  = {IW{1'b0}};
    localparam logic [IW-1:0] ONE_IDX   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ZERO_WORD = {W{1'b0}};

    // Sign bit alone decides: negative values, -0.0 and negative NaNs all clamp to 0.
    function automatic logic [W-1:0] relu_fn(input logic en, input logic [W-1:0] x);
        logic [W-1:0] y;
        if (en && x[W-1]) begin
            y = ZERO_WORD;
        end else begin
            y = x;
        end
        return y;
    endfunction

    logic [1:0]    state_r,      state_nx;
    logic [IW-1:0] wr_cnt_r,     wr_cnt_nx;
    logic [IW-1:0] rd_cnt_r,     rd_cnt_nx;
    logic          relu_q_r,     relu_q_nx;
    logic          ovf_r,        ovf_nx;
    logic          dp_restart_r, dp_restart_nx;
    logic          busy_r,       busy_nx;
    logic          done_r,       done_nx;
    logic          out_valid_r,  out_valid_nx;
    logic          out_last_r,   out_last_nx;
    logic [IW-1:0] out_idx_r,    out_idx_nx;
    logic [W-1:0]  out_data_r,   out_data_nx;
    logic          endf_q_r;

    logic [W-1:0]  buf_mem_r [NEURONS];
    logic          edge_s;
    logic          capture_s;
    logic          xfer_s;
    logic [IW-1:0] sel_idx_s;
    logic [W-1:0]  sel_word_s;

    assign edge_s    = endf && !endf_q_r;
    assign capture_s = edge_s && (state_r == S_COLLECT);
    assign xfer_s    = out_valid_r && out.out_ready;

    // Buffer read port: word 0 when entering drain, else the word after rd_cnt.
    always_comb begin
        sel_word_s = ZERO_WORD;
        if (state_r == S_DRAIN) begin
            sel_idx_s = rd_cnt_r + ONE_IDX;
        end else begin
            sel_idx_s = ZERO_IDX;
        end
        for (int i = 0; i < NEURONS; i++) begin
            sel_word_s = sel_word_s | ({W{sel_idx_s == IW'(i)}} & buf_mem_r[i]);
        end
    end

    // Next-state and next-output computation for the collect/drain sequencer.
    always_comb begin
        state_nx      = state_r;
        wr_cnt_nx     = wr_cnt_r;
        rd_cnt_nx     = rd_cnt_r;
        relu_q_nx     = relu_q_r;
        ovf_nx        = ovf_r | (edge_s && (state_r != S_COLLECT));
        dp_restart_nx = 1'b0;
        done_nx       = 1'b0;
        out_valid_nx  = out_valid_r;
        out_last_nx   = out_last_r;
        out_idx_nx    = out_idx_r;
        out_data_nx   = out_data_r;

        case (state_r)
            S_IDLE: begin
                // Start overrides an ovf set by an endf edge in the same cycle.
                if (start) begin
                    state_nx      = S_COLLECT;
                    wr_cnt_nx     = ZERO_IDX;
                    rd_cnt_nx     = ZERO_IDX;
                    relu_q_nx     = relu_en;
                    ovf_nx        = 1'b0;
                    dp_restart_nx = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (edge_s) begin
                    wr_cnt_nx = wr_cnt_r + ONE_IDX;
                    if (wr_cnt_r == LAST_IDX) begin
                        state_nx     = S_DRAIN;
                        out_valid_nx = 1'b1;
                        out_data_nx  = sel_word_s;
                        out_idx_nx   = ZERO_IDX;
                        out_last_nx  = 1'b0;
                    end else begin
                        dp_restart_nx = 1'b1;
                    end
                end else begin
                    state_nx = S_COLLECT;
                end
            end
            S_DRAIN: begin
                if (xfer_s) begin
                    rd_cnt_nx = rd_cnt_r + ONE_IDX;
                    if (out_last_r) begin
                        state_nx     = S_IDLE;
                        out_valid_nx = 1'b0;
                        out_last_nx  = 1'b0;
                        out_idx_nx   = ZERO_IDX;
                        out_data_nx  = ZERO_WORD;
                        done_nx      = 1'b1;
                    end else begin
                        out_data_nx = sel_word_s;
                        out_idx_nx  = rd_cnt_r + ONE_IDX;
                        out_last_nx = ((rd_cnt_r + ONE_IDX) == LAST_IDX);
                    end
                end else begin
                    state_nx = S_DRAIN;
                end
            end
            default: begin
                state_nx     = S_IDLE;
                out_valid_nx = 1'b0;
                out_last_nx  = 1'b0;
                out_idx_nx   = ZERO_IDX;
                out_data_nx  = ZERO_WORD;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    // Sequencer state, counters and all output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            wr_cnt_r     <= ZERO_IDX;
            rd_cnt_r     <= ZERO_IDX;
            relu_q_r     <= 1'b0;
            ovf_r        <= 1'b0;
            dp_restart_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_idx_r    <= ZERO_IDX;
            out_data_r   <= ZERO_WORD;
            endf_q_r     <= 1'b0;
        end else begin
            state_r      <= state_nx;
            wr_cnt_r     <= wr_cnt_nx;
            rd_cnt_r     <= rd_cnt_nx;
            relu_q_r     <= relu_q_nx;
            ovf_r        <= ovf_nx;
            dp_restart_r <= dp_restart_nx;
            busy_r       <= busy_nx;
            done_r       <= done_nx;
            out_valid_r  <= out_valid_nx;
            out_last_r   <= out_last_nx;
            out_idx_r    <= out_idx_nx;
            out_data_r   <= out_data_nx;
            endf_q_r     <= endf;
        end
    end

    // Result buffer; contents are don't-care after reset so it carries none.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NEURONS; i++) begin
            if (capture_s && (wr_cnt_r == IW'(i))) begin
                buf_mem_r[i] <= relu_fn(relu_q_r, result);
            end
        end
    end

    assign dp_restart    = dp_restart_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign ovf           = ovf_r;
    assign out.out_valid = out_valid_r;
    assign out.out_last  = out_last_r;
    assign out.out_idx   = out_idx_r;
    assign out.out_data  = out_data_r;

endmodule

// File: tb/tb_layer_result_collector.sv
// Directed-sequence bench with randomized data and handshake, checked against
// a queue-based reference of the collected layer vector.
module tb_layer_result_collector;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 8;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         relu_en = 1'b0;
    logic         endf = 1'b0;
    logic [W-1:0] result = '0;
    logic         dp_restart, busy, done, ovf;

    layer_result_collector_if #(.W(W), .IW(IW)) out_if ();

    layer_result_collector #(.NEURONS(N), .W(W), .IW(IW)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .relu_en    (relu_en),
        .result     (result),
        .endf       (endf),
        .dp_restart (dp_restart),
        .out        (out_if),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int restart_cnt = 0;
    int done_cnt = 0;
    logic [W-1:0] vals [N];
    bit pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always @(negedge CLK) begin
        if (dp_restart) restart_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a negative-signed word (sign bit set) becomes zero under ReLU.
    function automatic logic [W-1:0] model(input bit relu, input logic [W-1:0] x);
        if (relu && $signed(x) < 0) return '0;
        return x;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_restart"}, dp_restart, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_valid"}, out_if.out_valid, 0);
        check({tag, "_data"}, out_if.out_data, 0);
        check({tag, "_idx"}, out_if.out_idx, 0);
        check({tag, "_last"}, out_if.out_last, 0);
    endtask

    task automatic run_layer(input bit relu, input int hold, input int ready_mode,
                             input bit start_mid, input bit endf_with_start, input bit drain_endf);
        logic [W-1:0] exp_q [$];
        logic [W-1:0] held;
        int r0, d0, k, budget, pj;
        bit stalled, rdy;
        for (int i = 0; i < N; i++) exp_q.push_back(model(relu, vals[i]));
        r0 = restart_cnt;
        d0 = done_cnt;
        @(negedge CLK);
        start = 1'b1; relu_en = relu; endf = endf_with_start;
        @(negedge CLK);
        start = 1'b0; relu_en = ~relu; endf = 1'b0;
        check("busy_after_start", busy, 1);
        check("restart_after_start", dp_restart, 1);
        check("ovf_after_start", ovf, 0);
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            result = vals[i]; endf = 1'b1;
            @(negedge CLK);
            if (i < N - 1) begin
                check("restart_after_capture", dp_restart, 1);
            end else begin
                check("last_no_restart", dp_restart, 0);
                check("first_valid", out_if.out_valid, 1);
                check("first_idx", out_if.out_idx, 0);
            end
            for (int h = 1; h < hold; h++) begin
                @(negedge CLK);
                check("held_endf_no_restart", dp_restart, 0);
            end
            endf = 1'b0; result = $urandom;
            if (start_mid && i == 1) begin
                start = 1'b1;
                @(negedge CLK);
                start = 1'b0;
            end
            if (i < N - 1) @(negedge CLK);
        end
        k = 0; budget = 0; pj = 0; stalled = 1'b0; held = '0;
        while (k < N && budget < 200) begin
            check("valid_in_drain", out_if.out_valid, 1);
            if (stalled) check("stall_stable", out_if.out_data, held);
            check("data", out_if.out_data, exp_q[k]);
            check("idx", out_if.out_idx, k);
            check("last", out_if.out_last, (k == N - 1));
            check("no_done_in_drain", done, 0);
            if (ready_mode == 0) rdy = 1'b1;
            else if (ready_mode == 1) rdy = pattern[pj % 7];
            else rdy = 1'($urandom_range(0, 1));
            pj++;
            out_if.out_ready = rdy;
            endf = (drain_endf && budget == 1);
            held = out_if.out_data;
            stalled = !rdy;
            if (rdy) k++;
            @(negedge CLK);
            budget++;
        end
        check("drain_complete", k, N);
        out_if.out_ready = 1'b0; endf = 1'b0;
        check("valid_after_last", out_if.out_valid, 0);
        check("done_pulse", done, 1);
        check("busy_after_last", busy, 0);
        @(negedge CLK);
        check("done_single", done, 0);
        check("restart_count", restart_cnt - r0, N);
        check("done_count", done_cnt - d0, 1);
        check("ovf_end", ovf, drain_endf);
    endtask

    initial begin
        int d0;
        out_if.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge CLK);
        check_all_zero("idle");

        vals = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'h00000000};
        run_layer(1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
        run_layer(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);

        vals = '{32'h80000000, $urandom, $urandom | 32'h80000000, $urandom};
        run_layer(1'b1, 1, 2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) vals[i] = $urandom;
        run_layer(1'($urandom_range(0, 1)), 5, 1, 1'b0, 1'b0, 1'b0);

        // endf edge while idle must set ovf and keep it
        @(negedge CLK); endf = 1'b1;
        @(negedge CLK); endf = 1'b0;
        check("ovf_idle_edge", ovf, 1);
        repeat (3) @(negedge CLK);
        check("ovf_sticky", ovf, 1);
        check("idle_not_busy", busy, 0);

        for (int i = 0; i < N; i++) vals[i] = $urandom;
        run_layer(1'b0, 1, 2, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) vals[i] = $urandom;
        run_layer(1'b1, 2, 0, 1'b0, 1'b1, 1'b1);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) vals[i] = $urandom;
            run_layer(1'($urandom_range(0, 1)), $urandom_range(1, 3), 2, 1'b0, 1'b0, 1'b0);
        end

        // abort mid-layer with an asynchronous reset
        for (int i = 0; i < N; i++) vals[i] = $urandom;
        d0 = done_cnt;
        @(negedge CLK); start = 1'b1; relu_en = 1'b0;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            result = vals[i]; endf = 1'b1;
            @(negedge CLK);
            endf = 1'b0;
            if (i == 0) @(negedge CLK);
        end
        check("abort_restart_pending", dp_restart, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);
        check_all_zero("after_abort");

        for (int i = 0; i < N; i++) vals[i] = $urandom;
        run_layer(1'b0, 1, 2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
